// File: rtl/store_buffer.sv
// Post-retirement store buffer: circular FIFO of committed stores draining to the D-cache, with byte-granular load forwarding.
// Latency: push visible on the drain port one cycle later; forwarding is combinational from registered entries.
// Backpressure: sb_full (registered count) stalls the store queue; drain head is held stable until cache2sb_grant.

package store_buffer_pkg;
  // Packet width is fixed here; store_buffer's XLEN must match it.
  localparam int PKT_XLEN = 32;

  typedef struct packed {
    logic [PKT_XLEN-1:0] PC;
    logic [PKT_XLEN-1:0] addr;
    logic [PKT_XLEN-1:0] data;
    logic [3:0]          store_byte;
  } SQ_2_SB_PACKET;
endpackage

module store_buffer #(
  parameter int XLEN        = 32,
  parameter int SB_CAPACITY = 4,
  parameter int SB_LEN      = $clog2(SB_CAPACITY)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sq2sb_valid,
  input  store_buffer_pkg::SQ_2_SB_PACKET sq2sb_packet,
  output logic                           sb_full,
  output logic                           sb_empty,
  output logic                           sb2cache_req_valid,
  output logic [XLEN-1:0]                sb2cache_addr,
  output logic [XLEN-1:0]                sb2cache_data,
  output logic [3:0]                     sb2cache_byte_en,
  input  logic                           cache2sb_grant,
  input  logic [XLEN-1:0]                lb_lookup_addr,
  input  logic [3:0]                     lb_lookup_bytes,
  output logic                           sb_fwd_hit,
  output logic                           sb_fwd_partial,
  output logic [XLEN-1:0]                sb_fwd_data
);

  // Entry storage and queue pointers
  logic [XLEN-1:0]        addr_q  [SB_CAPACITY];
  logic [XLEN-1:0]        addr_d  [SB_CAPACITY];
  logic [XLEN-1:0]        data_q  [SB_CAPACITY];
  logic [XLEN-1:0]        data_d  [SB_CAPACITY];
  logic [3:0]             be_q    [SB_CAPACITY];
  logic [3:0]             be_d    [SB_CAPACITY];
  logic [SB_CAPACITY-1:0] valid_q, valid_d;
  logic [SB_LEN-1:0]      head_q, head_d;
  logic [SB_LEN-1:0]      tail_q, tail_d;
  logic [SB_LEN:0]        count_q, count_d;

  logic                   push;
  logic                   pop;

  // Entry slot holding the i-th oldest store, i = 0 being the head
  logic [SB_LEN-1:0]      age_idx [SB_CAPACITY];
  logic [3:0]             fwd_cov;
  logic [XLEN-1:0]        fwd_lane;
  logic [3:0]             covered;

  // PC travels with the packet for debug only; low lookup address bits select lanes via lb_lookup_bytes
  logic                   unused_ok;
  assign unused_ok = ^{sq2sb_packet.PC, lb_lookup_addr[1:0]};

  // Flags depend only on registered count so a same-cycle pop never frees a slot for push
  assign sb_full  = (count_q == (SB_LEN+1)'(SB_CAPACITY));
  assign sb_empty = (count_q == '0);
  assign push     = sq2sb_valid && !sb_full;
  assign pop      = !sb_empty && cache2sb_grant;

  assign sb2cache_req_valid = !sb_empty;
  assign sb2cache_addr      = {addr_q[head_q][XLEN-1:2], 2'b00};
  assign sb2cache_data      = data_q[head_q];
  assign sb2cache_byte_en   = be_q[head_q];

  // Next-state: write at tail on push, retire head on pop, adjust count
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (push) begin
      addr_d[tail_q]  = sq2sb_packet.addr;
      data_d[tail_q]  = sq2sb_packet.data;
      be_d[tail_q]    = sq2sb_packet.store_byte;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + SB_LEN'(1);
    end
    // push and pop never target the same slot: that would need count 0 or full
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + SB_LEN'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (SB_LEN+1)'(1);
      2'b01:   count_d = count_q - (SB_LEN+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset; reset discards all buffered stores
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage; qualified by valid_q so it needs no reset
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  // Map age order to physical slots starting at head
  always_comb begin
    for (int i = 0; i < SB_CAPACITY; i++) begin
      age_idx[i] = head_q + SB_LEN'(i);
    end
  end

  // Forwarding scan oldest to youngest so the youngest matching store wins each lane
  always_comb begin
    fwd_cov  = '0;
    fwd_lane = '0;
    for (int i = 0; i < SB_CAPACITY; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (valid_q[age_idx[i]] &&
            (addr_q[age_idx[i]][XLEN-1:2] == lb_lookup_addr[XLEN-1:2]) &&
            be_q[age_idx[i]][b]) begin
          fwd_cov[b]          = 1'b1;
          fwd_lane[8*b +: 8]  = data_q[age_idx[i]][8*b +: 8];
        end
      end
    end
  end

  // Hit/partial classification and zeroing of uncovered lanes
  always_comb begin
    covered     = fwd_cov & lb_lookup_bytes;
    sb_fwd_data = '0;
    for (int b = 0; b < 4; b++) begin
      if (covered[b]) begin
        sb_fwd_data[8*b +: 8] = fwd_lane[8*b +: 8];
      end
    end
    sb_fwd_hit     = (covered == lb_lookup_bytes) && (lb_lookup_bytes != 4'b0000);
    sb_fwd_partial = (covered != 4'b0000) && !sb_fwd_hit;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: drain order scoreboard plus directed forwarding and flag vectors.
// Drain checks run in a negedge monitor; forwarding checks are combinational, one cycle window each.
// Grant is driven directly by stimulus to exercise stall, back-to-back drain and reset mid-drain.

module tb_store_buffer;
  import store_buffer_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic          sq2sb_valid;
  SQ_2_SB_PACKET pkt;
  logic          sb_full, sb_empty, sb2cache_req_valid;
  logic [31:0]   sb2cache_addr, sb2cache_data;
  logic [3:0]    sb2cache_byte_en;
  logic          cache2sb_grant;
  logic [31:0]   lb_lookup_addr;
  logic [3:0]    lb_lookup_bytes;
  logic          sb_fwd_hit, sb_fwd_partial;
  logic [31:0]   sb_fwd_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   allow_full_push = 1'b0;

  store_buffer #(.XLEN(32), .SB_CAPACITY(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .sq2sb_valid        (sq2sb_valid),
    .sq2sb_packet       (pkt),
    .sb_full            (sb_full),
    .sb_empty           (sb_empty),
    .sb2cache_req_valid (sb2cache_req_valid),
    .sb2cache_addr      (sb2cache_addr),
    .sb2cache_data      (sb2cache_data),
    .sb2cache_byte_en   (sb2cache_byte_en),
    .cache2sb_grant     (cache2sb_grant),
    .lb_lookup_addr     (lb_lookup_addr),
    .lb_lookup_bytes    (lb_lookup_bytes),
    .sb_fwd_hit         (sb_fwd_hit),
    .sb_fwd_partial     (sb_fwd_partial),
    .sb_fwd_data        (sb_fwd_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input bit expect_accept);
    exp_t e;
    sq2sb_valid    = 1'b1;
    pkt.PC         = 32'h8000_0000 ^ a;
    pkt.addr       = a;
    pkt.data       = d;
    pkt.store_byte = be;
    if (expect_accept) begin
      e.addr = {a[31:2], 2'b00};
      e.data = d;
      e.be   = be;
      exp_q.push_back(e);
    end
    tick();
    sq2sb_valid = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [31:0] a, input logic [3:0] bytes,
                        input logic h, input logic p, input logic [31:0] d);
    lb_lookup_addr  = a;
    lb_lookup_bytes = bytes;
    #1;
    check({name, "_hit"},     32'(sb_fwd_hit),     32'(h));
    check({name, "_partial"}, 32'(sb_fwd_partial), 32'(p));
    check({name, "_data"},    sb_fwd_data,         d);
  endtask

  task automatic drain_all(input string name, input int bound);
    cache2sb_grant = 1'b1;
    for (int i = 0; i < bound && !sb_empty; i++) tick();
    cache2sb_grant = 1'b0;
    check({name, "_empty"},    32'(sb_empty), 32'd1);
    check({name, "_sb_left"},  32'(exp_q.size()), 32'd0);
  endtask

  // Drain monitor: every granted request must match the oldest outstanding store
  always @(negedge clock) begin
    if (!reset && sb2cache_req_valid && cache2sb_grant) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL drain_unexpected: got addr 0x%08h required no request", sb2cache_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("drain_addr", sb2cache_addr, e.addr);
        check("drain_data", sb2cache_data, e.data);
        check("drain_be",   32'(sb2cache_byte_en), 32'(e.be));
      end
    end
  end

  // Store queue protocol: no retire while full unless a test deliberately violates it
  always @(posedge clock) begin
    if (!reset && sq2sb_valid && sb_full && !allow_full_push) begin
      failures++;
      $display("FAIL push_while_full: got sq2sb_valid=1 with sb_full=1 required no push");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 required earlier finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    sq2sb_valid     = 1'b0;
    pkt             = '0;
    cache2sb_grant  = 1'b0;
    lb_lookup_addr  = '0;
    lb_lookup_bytes = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_empty",   32'(sb_empty), 32'd1);
    check("rst_full",    32'(sb_full), 32'd0);
    check("rst_req",     32'(sb2cache_req_valid), 32'd0);
    check("rst_hit",     32'(sb_fwd_hit), 32'd0);
    check("rst_partial", 32'(sb_fwd_partial), 32'd0);
    check("rst_fwd",     sb_fwd_data, 32'd0);

    // Basic drain with stall then back-to-back grants
    push(32'h100, 4'hF, 32'hD000_0100, 1'b1);
    check("push1_req", 32'(sb2cache_req_valid), 32'd1);
    push(32'h104, 4'hF, 32'hD000_0104, 1'b1);
    push(32'h108, 4'hF, 32'hD000_0108, 1'b1);
    check("basic_req",   32'(sb2cache_req_valid), 32'd1);
    check("basic_head",  sb2cache_addr, 32'h100);
    tick();
    tick();
    check("stall_head",  sb2cache_addr, 32'h100);
    check("stall_data",  sb2cache_data, 32'hD000_0100);
    cache2sb_grant = 1'b1;
    tick();
    check("basic_2nd",   sb2cache_addr, 32'h104);
    tick();
    check("basic_3rd",   sb2cache_addr, 32'h108);
    tick();
    cache2sb_grant = 1'b0;
    check("basic_empty", 32'(sb_empty), 32'd1);
    check("basic_noreq", 32'(sb2cache_req_valid), 32'd0);

    // Full, ignored push, wrap
    do_reset();
    push(32'h400, 4'hF, 32'hC0DE_0000, 1'b1);
    push(32'h404, 4'h3, 32'hC0DE_0001, 1'b1);
    push(32'h40B, 4'h8, 32'hC0DE_0002, 1'b1);
    push(32'h40C, 4'hF, 32'hC0DE_0003, 1'b1);
    check("full_set",   32'(sb_full), 32'd1);
    check("full_nempt", 32'(sb_empty), 32'd0);
    allow_full_push = 1'b1;
    push(32'h500, 4'hF, 32'hBAD0_0500, 1'b0);
    allow_full_push = 1'b0;
    check("full_still", 32'(sb_full), 32'd1);
    check("full_head",  sb2cache_addr, 32'h400);
    lookup("full_ignored", 32'h500, 4'hF, 1'b0, 1'b0, 32'h0);
    cache2sb_grant = 1'b1;
    tick();
    cache2sb_grant = 1'b0;
    check("pop1_full",  32'(sb_full), 32'd0);
    check("pop1_head",  sb2cache_addr, 32'h404);
    push(32'h510, 4'hF, 32'hC0DE_0510, 1'b1);
    check("wrap_full",  32'(sb_full), 32'd1);
    drain_all("wrap", 8);

    // Simultaneous push and pop at count 2
    push(32'h600, 4'hF, 32'h6000_0000, 1'b1);
    push(32'h604, 4'hF, 32'h6000_0004, 1'b1);
    cache2sb_grant = 1'b1;
    push(32'h608, 4'hF, 32'h6000_0008, 1'b1);
    cache2sb_grant = 1'b0;
    check("simul_head", sb2cache_addr, 32'h604);
    check("simul_full", 32'(sb_full), 32'd0);
    cache2sb_grant = 1'b1;
    tick();
    check("simul_c1_head",  sb2cache_addr, 32'h608);
    check("simul_c1_nempt", 32'(sb_empty), 32'd0);
    tick();
    check("simul_c0_empty", 32'(sb_empty), 32'd1);
    // Push into empty with grant high: nothing to pop, count becomes 1
    push(32'h700, 4'h1, 32'h0000_0077, 1'b1);
    check("empty_push_req",  32'(sb2cache_req_valid), 32'd1);
    check("empty_push_addr", sb2cache_addr, 32'h700);
    tick();
    cache2sb_grant = 1'b0;
    check("empty_push_drained", 32'(sb_empty), 32'd1);

    // Youngest-wins forwarding, and forwarding from an entry being popped
    do_reset();
    push(32'h200, 4'hF, 32'h1111_1111, 1'b1);
    push(32'h200, 4'b0001, 32'h0000_00AA, 1'b1);
    lookup("young_full", 32'h200, 4'hF, 1'b1, 1'b0, 32'h1111_11AA);
    lookup("young_lane0", 32'h201, 4'b0001, 1'b1, 1'b0, 32'h0000_00AA);
    lookup("young_miss", 32'h204, 4'hF, 1'b0, 1'b0, 32'h0);
    cache2sb_grant = 1'b1;
    lookup("popping_fwd", 32'h200, 4'hF, 1'b1, 1'b0, 32'h1111_11AA);
    tick();
    cache2sb_grant = 1'b0;
    lookup("after_pop", 32'h200, 4'hF, 1'b0, 1'b1, 32'h0000_00AA);

    // Partial forwarding; a store being pushed this cycle does not forward
    do_reset();
    sq2sb_valid    = 1'b1;
    pkt.PC         = 32'h8000_0300;
    pkt.addr       = 32'h300;
    pkt.data       = 32'h0000_BEEF;
    pkt.store_byte = 4'b0011;
    exp_q.push_back('{addr: 32'h300, data: 32'h0000_BEEF, be: 4'b0011});
    lookup("pushing_nofwd", 32'h300, 4'b0011, 1'b0, 1'b0, 32'h0);
    tick();
    sq2sb_valid = 1'b0;
    lookup("part_word",  32'h300, 4'hF, 1'b0, 1'b1, 32'h0000_BEEF);
    lookup("part_lanes", 32'h302, 4'b0011, 1'b1, 1'b0, 32'h0000_BEEF);
    lookup("part_none",  32'h300, 4'b0100, 1'b0, 1'b0, 32'h0);
    lookup("part_zero",  32'h300, 4'b0000, 1'b0, 1'b0, 32'h0);

    // Reset mid-drain discards everything
    do_reset();
    push(32'h100, 4'hF, 32'hAAAA_0100, 1'b1);
    push(32'h104, 4'hF, 32'hAAAA_0104, 1'b1);
    push(32'h108, 4'hF, 32'hAAAA_0108, 1'b1);
    check("mid_req", 32'(sb2cache_req_valid), 32'd1);
    do_reset();
    check("mid_rst_empty", 32'(sb_empty), 32'd1);
    check("mid_rst_req",   32'(sb2cache_req_valid), 32'd0);
    check("mid_rst_full",  32'(sb_full), 32'd0);
    lookup("mid_rst_fwd1", 32'h104, 4'hF, 1'b0, 1'b0, 32'h0);
    lookup("mid_rst_fwd2", 32'h100, 4'b0001, 1'b0, 1'b0, 32'h0);

    tick();
    check("final_sb_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
